// File: rtl/npu_output_streamer_if.sv
// Byte stream from the NPU output streamer toward the host/UART/DMA side.
// The master drives data, valid and framing flags; the slave drives ready.
interface npu_output_streamer_if #(
   parameter int DW = 8
);
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last_row;
   logic          out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last_row,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last_row,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/npu_output_streamer.sv
// Snapshots the NPU result matrix on the rising edge of done and streams it row-major.
// Optional macro OUT_STREAM_CHECKSUM_EN appends one XOR checksum beat per frame.
module npu_output_streamer #(
   parameter int ROWS = 10,
   parameter int COLS = 10,
   parameter int DW   = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              done,
   input  logic [ROWS-1:0][COLS-1:0][DW-1:0] final_output,
   npu_output_streamer_if.master             out_if,
   output logic                              busy,
   output logic                              frame_done,
   output logic                              overrun
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_FINISH
   } state_e;

   state_e                            r_state;
   state_e                            w_state_next;
   logic                              r_done_q;
   logic [RW-1:0]                     r_row;
   logic [CW-1:0]                     r_col;
   logic [RW-1:0]                     w_row_next;
   logic [CW-1:0]                     w_col_next;
   logic [DW-1:0]                     r_out_data;
   logic                              r_overrun;
   logic [ROWS-1:0][COLS-1:0][DW-1:0] r_buf;

   logic w_start_edge;
   logic w_streaming;
   logic w_xfer;
   logic w_capture;
   logic w_overrun_set;
   logic w_last_elem;
   logic w_data_phase;
   logic w_final_beat;

   assign w_start_edge = done & ~r_done_q;
   assign w_streaming  = (r_state == ST_STREAM);
   assign w_xfer       = w_streaming & out_if.out_ready;
   assign w_last_elem  = (r_row == LAST_ROW) && (r_col == LAST_COL);

`ifdef OUT_STREAM_CHECKSUM_EN
   logic [DW-1:0] r_cks;
   logic          r_cks_phase;

   assign w_data_phase = ~r_cks_phase;
   assign w_final_beat = r_cks_phase;
`else
   assign w_data_phase = 1'b1;
   assign w_final_beat = w_last_elem;
`endif

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_next;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_next  = r_state;
      w_capture     = 1'b0;
      w_overrun_set = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_edge) begin
               w_capture    = 1'b1;
               w_state_next = ST_STREAM;
            end
         end
         ST_STREAM: begin
            w_overrun_set = w_start_edge;
            if (w_xfer && w_final_beat) w_state_next = ST_FINISH;
         end
         ST_FINISH: begin
            w_overrun_set = w_start_edge;
            w_state_next  = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_col_next = r_col + 1'b1;
      w_row_next = r_row;
      if (r_col == LAST_COL) begin
         w_col_next = '0;
         w_row_next = r_row + 1'b1;
      end
   end

   // NOTE: the snapshot buffer is plain storage with no reset; only control state is reset.
   always_ff @(posedge clk) begin
      if (rst && w_capture) r_buf <= final_output;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_done_q    <= 1'b0;
         r_overrun   <= 1'b0;
         r_row       <= '0;
         r_col       <= '0;
         r_out_data  <= '0;
`ifdef OUT_STREAM_CHECKSUM_EN
         r_cks       <= '0;
         r_cks_phase <= 1'b0;
`endif
      end else begin
         r_done_q <= done;
         if (w_overrun_set) r_overrun <= 1'b1;

         if (w_capture) begin
            r_row      <= '0;
            r_col      <= '0;
            r_out_data <= final_output[0][0];
`ifdef OUT_STREAM_CHECKSUM_EN
            r_cks       <= '0;
            r_cks_phase <= 1'b0;
`endif
         end else if (w_xfer && w_data_phase) begin
`ifdef OUT_STREAM_CHECKSUM_EN
            r_cks <= r_cks ^ r_out_data;
            if (w_last_elem) begin
               r_cks_phase <= 1'b1;
               r_out_data  <= r_cks ^ r_out_data;
            end else begin
               r_row      <= w_row_next;
               r_col      <= w_col_next;
               r_out_data <= r_buf[w_row_next][w_col_next];
            end
`else
            // Counters park on the last element; the next capture clears them.
            if (!w_last_elem) begin
               r_row      <= w_row_next;
               r_col      <= w_col_next;
               r_out_data <= r_buf[w_row_next][w_col_next];
            end
`endif
         end
      end
   end

   assign out_if.out_data     = r_out_data;
   assign out_if.out_valid    = w_streaming;
   assign out_if.out_last_row = w_streaming & w_data_phase & (r_col == LAST_COL);
   assign out_if.out_last     = w_streaming & w_final_beat;

   assign busy       = (r_state != ST_IDLE);
   assign frame_done = (r_state == ST_FINISH);
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_npu_output_streamer.sv
// Directed bench for npu_output_streamer: drain, backpressure, snapshot, held done,
// overrun and mid-frame reset, with expected bytes computed from the loaded ramp.
module tb_npu_output_streamer;

   localparam int ROWS = 10;
   localparam int COLS = 10;
   localparam int DW   = 8;
`ifdef OUT_STREAM_CHECKSUM_EN
   localparam int NBEATS = ROWS * COLS + 1;
`else
   localparam int NBEATS = ROWS * COLS;
`endif

   logic                              clk = 1'b0;
   logic                              rst;
   logic                              done;
   logic [ROWS-1:0][COLS-1:0][DW-1:0] final_output;
   logic                              busy;
   logic                              frame_done;
   logic                              overrun;

   int n_checks = 0;
   int n_errors = 0;

   npu_output_streamer_if #(.DW(DW)) u_if ();

   npu_output_streamer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .done         (done),
      .final_output (final_output),
      .out_if       (u_if.master),
      .busy         (busy),
      .frame_done   (frame_done),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic load_ramp(input int base);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            final_output[r][c] = DW'(base + r * COLS + c);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"},    32'(u_if.out_valid),    0);
      check({tag, "_last"},     32'(u_if.out_last),     0);
      check({tag, "_last_row"}, 32'(u_if.out_last_row), 0);
      check({tag, "_busy"},     32'(busy),              0);
      check({tag, "_fdone"},    32'(frame_done),        0);
      check({tag, "_data"},     32'(u_if.out_data),     0);
   endtask

   // Raises done at a negedge; the following negedge must already show the first beat.
   task automatic start_frame();
      done = 1'b0;
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      check("start_valid", 32'(u_if.out_valid), 1);
      check("start_busy",  32'(busy),           1);
   endtask

   // mode 0: ready always high; mode 1: ready 1,0,0,1 repeating.
   // ovr_beat raises done at that beat index; abort_beat pulses reset there.
   task automatic drain(input int mode, input int base, input int ovr_beat, input int abort_beat);
      int          beat = 0;
      int          cyc = 0;
      bit          stalled = 0;
      bit          fd_early = 0;
      logic [7:0]  prev = '0;
      logic [7:0]  exp_data;
      logic [7:0]  exp_cks = '0;
      logic        exp_lr;
      logic        exp_last;
      while (beat < NBEATS && cyc < 2000) begin
         u_if.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (beat == ovr_beat) done = 1'b1;
         if (stalled) check("stall_hold", 32'(u_if.out_data), 32'(prev));
         if (frame_done) fd_early = 1;
         check("valid_high", 32'(u_if.out_valid), 1);
         if (beat == abort_beat) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            check_idle_zero("abort");
            check("abort_overrun", 32'(overrun), 0);
            repeat (5) begin
               @(negedge clk);
               check("abort_no_fdone", 32'(frame_done), 0);
            end
            return;
         end
         if (u_if.out_ready) begin
            if (beat < ROWS * COLS) begin
               exp_data = 8'(base + beat);
               exp_lr   = (beat % COLS == COLS - 1);
               exp_last = (beat == NBEATS - 1);
               exp_cks  = exp_cks ^ exp_data;
            end else begin
               exp_data = exp_cks;
               exp_lr   = 1'b0;
               exp_last = 1'b1;
            end
            check("beat_data",     32'(u_if.out_data),     32'(exp_data));
            check("beat_last_row", 32'(u_if.out_last_row), 32'(exp_lr));
            check("beat_last",     32'(u_if.out_last),     32'(exp_last));
            beat++;
            stalled = 0;
         end else begin
            stalled = 1;
            prev    = u_if.out_data;
         end
         cyc++;
         @(negedge clk);
      end
      if (beat < NBEATS) check("drain_timeout", 32'(beat), 32'(NBEATS));
      if (mode == 0) check("drain_cycles", 32'(cyc), 32'(NBEATS));
      check("fdone_early", 32'(fd_early), 0);
      check("fdone_pulse", 32'(frame_done), 1);
      check("fdone_valid", 32'(u_if.out_valid), 0);
      check("fdone_busy",  32'(busy), 1);
      @(negedge clk);
      check("fdone_clear", 32'(frame_done), 0);
      check("end_busy",    32'(busy), 0);
   endtask

   initial begin
      bit saw_valid;
      rst            = 1'b0;
      done           = 1'b0;
      u_if.out_ready = 1'b0;
      load_ramp(1);
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      check("reset_overrun", 32'(overrun), 0);
      rst = 1'b1;
      @(negedge clk);

      // Basic drain with ready held high.
      start_frame();
      drain(0, 1, -1, -1);

      // Backpressure.
      start_frame();
      drain(1, 1, -1, -1);

      // Snapshot isolation: input changes right after capture.
      start_frame();
      final_output = '1;
      drain(1, 1, -1, -1);
      load_ramp(1);

      // Held done: one frame only, no overrun.
      start_frame();
      drain(0, 1, -1, -1);
      saw_valid = 0;
      repeat (180) begin
         @(negedge clk);
         if (u_if.out_valid) saw_valid = 1;
      end
      check("held_single_frame", 32'(saw_valid), 0);
      check("held_no_overrun",   32'(overrun),   0);
      done = 1'b0;
      @(negedge clk);

      // Overrun: second edge at beat 40, stream unchanged, flag sticky.
      start_frame();
      done = 1'b0;
      drain(0, 1, 39, -1);
      check("ovr_set", 32'(overrun), 1);
      done = 1'b0;
      repeat (3) @(negedge clk);
      check("ovr_sticky_idle", 32'(overrun), 1);
      check("ovr_idle_valid",  32'(u_if.out_valid), 0);
      load_ramp(101);
      start_frame();
      drain(0, 101, -1, -1);
      check("ovr_sticky_end", 32'(overrun), 1);

      // Reset at beat 57, then a fresh frame starts at element [0][0].
      load_ramp(1);
      start_frame();
      done = 1'b0;
      drain(0, 1, -1, 56);
      start_frame();
      drain(0, 1, -1, -1);
      check("final_overrun", 32'(overrun), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/npu_output_streamer.md
# npu_output_streamer

Reader side of the NPU result interface. Detects the NPU `done` edge and snapshots the 10x10 8-bit `final_output` matrix into an internal buffer. Streams the snapshot one byte per handshake, row-major, over a valid/ready interface toward the host/UART/DMA side. The NPU is freed to start the next frame while the previous result drains.

## Interface
Parameters:
- `ROWS`, 10, matrix rows
- `COLS`, 10, matrix columns
- `DW`, 8, element width (normalized output)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge)
- `done` in 1: NPU completion level; a 0->1 transition starts a frame
- `final_output` in [DW-1:0] x [ROWS-1:0][COLS-1:0]: NPU result matrix, valid while `done`=1
- `out_data` out DW: current element
- `out_valid` out 1: `out_data` is valid
- `out_ready` in 1: sink accepts the beat
- `out_last_row` out 1: current beat is the last column of a row
- `out_last` out 1: current beat is the final beat of the frame
- `busy` out 1: frame captured and not fully drained
- `frame_done` out 1: one-cycle pulse after the final handshake
- `overrun` out 1: sticky; a `done` edge arrived while `busy`

## Operation
- Edge detect: register `done_q` (reset 0). `start_edge = done & ~done_q`.
- FSM states: IDLE, STREAM, FINISH.
  - IDLE: on `start_edge`, copy the entire `final_output` into `buf`. Clear `row`/`col` to 0. Go to STREAM.
  - STREAM: `out_valid`=1 and `out_data = buf[row][col]`.
    - A beat transfers on `out_valid & out_ready`, then advances `col`. At `col==COLS-1`, `col` wraps to 0 and `row` increments.
    - The transfer of the last beat goes to FINISH.
    - With `out_ready`=0, `out_data`, `row`, `col` and `out_last*` hold stable.
  - FINISH: `frame_done`=1 for this cycle only, then IDLE.
- `out_last_row` = STREAM & `col==COLS-1`. `out_last` = STREAM on the final beat.
- `busy` = state != IDLE.
- `start_edge` while in STREAM or FINISH: ignored, `buf` untouched, `overrun` set. `overrun` clears only on reset.
- `start_edge` arriving in the same cycle that FINISH returns to IDLE is also an overrun and is dropped. A new frame requires a fresh edge while in IDLE.
- `final_output` changing after capture has no effect on the streamed data.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE; `out_valid`, `out_last`, `out_last_row`, `busy`, `frame_done`, `overrun`, `done_q` = 0; `out_data` = 0; `row`, `col` = 0. `buf` is not cleared.
- Reset mid-frame aborts the frame immediately. No `frame_done` is produced.
- Edge at cycle N (`done` sampled 1, `done_q` 0): capture at edge N, `out_valid`=1 from cycle N+1.
- Throughput: 1 beat/cycle when `out_ready` is held high.
  - Frame = ROWS*COLS = 100 beats, occupying cycles N+1..N+100.
  - `frame_done` pulses at N+101.
  - IDLE at N+102, when a new edge can be accepted.
- Valid/ready: `out_valid` never deasserts before its handshake. `out_data` is a registered output.

## Configuration
- `OUT_STREAM_CHECKSUM_EN` defined: one extra beat follows the last matrix element.
  - It carries the 8-bit XOR of all ROWS*COLS streamed elements.
  - `out_last`=1 moves to the checksum beat; `out_last_row`=0 on it.
  - Frame = 101 beats, and `frame_done` follows the checksum handshake.
  - The checksum accumulates on each handshake and clears at capture.
- Undefined: no checksum beat, and no checksum logic is present.

## Test plan
- Basic drain: `final_output[r][c]=r*10+c+1`, `out_ready`=1, `done` 0->1.
  - Expected: 100 beats with values 1..100 in order.
  - `out_last_row` on beats 10,20,..,100; `out_last` on beat 100; `frame_done` one cycle later.
  - With `OUT_STREAM_CHECKSUM_EN`: beat 101 = 0x64 with `out_last`.
- Backpressure: same matrix, `out_ready` toggles 1,0,0,1 repeating.
  - Expected: identical byte sequence, with `out_data` stable across every stalled cycle.
- Snapshot isolation: after capture, change `final_output` to all 0xFF.
  - Expected: the stream is still 1..100.
- Overrun: assert a second `done` edge at beat 40.
  - Expected: `overrun`=1 and stays set; the stream completes unchanged.
  - A new edge after IDLE streams the new matrix.
- Reset mid-frame: drive `rst`=0 for one clock at beat 57.
  - Expected: all outputs 0 next cycle; no `frame_done`; `overrun` cleared.
  - A following `done` edge restarts at element [0][0].
- Held done: keep `done`=1 for 300 cycles.
  - Expected: exactly one frame; `overrun` stays 0.
